// File: rtl/alu_issue_arb.sv
// rtl/alu_issue_arb.sv - round-robin issue arbiter in front of a shared int16 ALU
// Single-cycle ops issue back to back; mult ops block issue for two extra cycles.
module alu_issue_arb #(
    parameter int         NREQ    = 4,
    parameter logic [4:0] OP_MUL  = 5'h02,
    parameter logic [4:0] OP_MULI = 5'h03,
    parameter logic [4:0] OP_FMA  = 5'h04,
    localparam int        IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_en,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*5-1:0]   req_op,
    input  logic [NREQ*2-1:0]   req_cmp_mode,
    input  logic [NREQ-1:0]     req_pred,
    input  logic [NREQ*16-1:0]  req_a,
    input  logic [NREQ*16-1:0]  req_b,
    input  logic [NREQ*16-1:0]  req_c,
    output logic [4:0]          alu_op,
    output logic                alu_valid_in,
    output logic [1:0]          alu_cmp_mode,
    output logic                alu_pred_val,
    output logic [15:0]         alu_op_a,
    output logic [15:0]         alu_op_b,
    output logic [15:0]         alu_op_c,
    input  logic [15:0]         alu_result,
    input  logic                alu_valid_out,
    input  logic                alu_busy,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_data,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_grant, mul_id, winner, cand;
    logic           found, transfer, win_mult, exp_vo, err_now;
    logic [4:0]     win_op;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        cand   = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_op       = req_op[int'(winner)*5 +: 5];
        win_mult     = (win_op == OP_MUL) || (win_op == OP_MULI) || (win_op == OP_FMA);
        transfer     = (state == IDLE) && issue_en && found;
        req_ready    = '0;
        if (transfer) begin
            req_ready[winner] = 1'b1;
        end
        alu_valid_in = transfer;
        alu_op       = win_op;
        alu_cmp_mode = req_cmp_mode[int'(winner)*2 +: 2];
        alu_pred_val = req_pred[winner];
        alu_op_a     = req_a[int'(winner)*16 +: 16];
        alu_op_b     = req_b[int'(winner)*16 +: 16];
        alu_op_c     = req_c[int'(winner)*16 +: 16];
    end

    // ALU handshake expectations: busy covers the mult issue cycle and MUL1,
    // the mult result lands in MUL2.
    always_comb begin
        state_nxt = state;
        exp_vo    = 1'b0;
        err_now   = 1'b0;
        case (state)
            IDLE: begin
                exp_vo  = transfer && !win_mult;
                err_now = alu_busy && !(transfer && win_mult);
                if (transfer && win_mult) begin
                    state_nxt = MUL1;
                end
            end
            MUL1: begin
                state_nxt = MUL2;
                err_now   = !alu_busy;
            end
            MUL2: begin
                state_nxt = IDLE;
                exp_vo    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        err_now = err_now || (alu_valid_out != exp_vo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            mul_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            proto_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= alu_valid_out;
            if (transfer) begin
                last_grant <= winner;
            end
            if (transfer && win_mult) begin
                mul_id <= winner;
            end
            if (alu_valid_out) begin
                rsp_id   <= (state == MUL2) ? mul_id : winner;
                rsp_data <= alu_result;
            end
            if (err_now) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_arb.sv
// tb/tb_alu_issue_arb.sv - self-checking bench for alu_issue_arb with a behavioural ALU
module tb_alu_issue_arb;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_MUL  = 5'h02;
    localparam logic [4:0] OP_MULI = 5'h03;
    localparam logic [4:0] OP_FMA  = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_en = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [19:0] req_op = '0;
    logic [7:0]  req_cmp_mode = '0;
    logic [3:0]  req_pred = '0;
    logic [63:0] req_a = '0, req_b = '0, req_c = '0;
    logic [4:0]  alu_op;
    logic        alu_valid_in;
    logic [1:0]  alu_cmp_mode;
    logic        alu_pred_val;
    logic [15:0] alu_op_a, alu_op_b, alu_op_c;
    logic [15:0] alu_result;
    logic        alu_valid_out, alu_busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        proto_err;
    logic        force_vo = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_arb dut (
        .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_cmp_mode(req_cmp_mode), .req_pred(req_pred),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .alu_op(alu_op), .alu_valid_in(alu_valid_in), .alu_cmp_mode(alu_cmp_mode),
        .alu_pred_val(alu_pred_val), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_op_c(alu_op_c), .alu_result(alu_result), .alu_valid_out(alu_valid_out),
        .alu_busy(alu_busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .proto_err(proto_err)
    );

    function automatic logic is_mult(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULI) || (op == OP_FMA);
    endfunction

    function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
        case (op)
            OP_ADD:          return a + b;
            OP_SUB:          return a - b;
            OP_MUL, OP_MULI: return a * b;
            OP_FMA:          return a * b + c;
            OP_XOR:          return a ^ b;
            default:         return a & b;
        endcase
    endfunction

    // Behavioural ALU: single-cycle result combinational, mult result two cycles later.
    logic        mv1, mv2;
    logic [15:0] mr1, mr2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv1 <= 1'b0; mv2 <= 1'b0; mr1 <= '0; mr2 <= '0;
        end else begin
            mv1 <= alu_valid_in && is_mult(alu_op);
            mr1 <= alu_fn(alu_op, alu_op_a, alu_op_b, alu_op_c);
            mv2 <= mv1;
            mr2 <= mr1;
        end
    end
    assign alu_valid_out = (alu_valid_in && !is_mult(alu_op)) || mv2 || force_vo;
    assign alu_result    = mv2 ? mr2 : alu_fn(alu_op, alu_op_a, alu_op_b, alu_op_c);
    assign alu_busy      = (alu_valid_in && is_mult(alu_op)) || mv1;

    task automatic set_req(input int i, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
        req_valid[i]           = 1'b1;
        req_op[i*5 +: 5]       = op;
        req_a[i*16 +: 16]      = a;
        req_b[i*16 +: 16]      = b;
        req_c[i*16 +: 16]      = c;
        req_cmp_mode[i*2 +: 2] = 2'(i);
        req_pred[i]            = i[0];
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        issue_en  = 1'b0;
        force_vo  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        tests++; if (rsp_data !== 16'd0) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        tests++; if (req_ready !== 4'b0 || alu_valid_in !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got %b/%b want 0000/0", req_ready, alu_valid_in);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        issue_en = 1'b1;
        set_req(0, OP_ADD, 16'd3, 16'd4, 16'd0);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL add_ready: got %b want 0001", req_ready); end
        tests++; if (alu_valid_in !== 1'b1 || alu_op !== OP_ADD || alu_op_a !== 16'd3 || alu_op_b !== 16'd4) begin
            fails++; $display("FAIL add_alu_drive: got v=%b op=%0d a=%0d b=%0d want v=1 op=0 a=3 b=4",
                              alu_valid_in, alu_op, alu_op_a, alu_op_b);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd7) begin
            fails++; $display("FAIL add_rsp: got v=%b id=%0d d=%0d want v=1 id=0 d=7", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0 || rsp_data !== 16'd7) begin
            fails++; $display("FAIL add_rsp_hold: got v=%b d=%0d want v=0 d=7", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_round_robin();
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [15:0] pa [4];
        logic [15:0] exp_d;
        int          prev;
        do_reset();
        issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pa[i] = 16'($urandom);
            set_req(i, OP_ADD, pa[i], 16'(i + 1), 16'd0);
        end
        prev  = -1;
        exp_d = '0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = '0;
            #1;
            if (k < 5) begin
                tests++; if (req_ready !== 4'(1 << order[k])) begin
                    fails++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << order[k]));
                end
                tests++; if (alu_op_a !== pa[order[k]]) begin
                    fails++; $display("FAIL rr_op_a[%0d]: got %h want %h", k, alu_op_a, pa[order[k]]);
                end
            end
            if (prev >= 0) begin
                tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(prev) || rsp_data !== exp_d) begin
                    fails++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                                      k, rsp_valid, rsp_id, rsp_data, prev, exp_d);
                end
            end
            if (k < 5) begin
                prev  = order[k];
                exp_d = pa[prev] + 16'(prev + 1);
            end
            @(negedge clk);
            if (k < 5) begin
                pa[prev] = 16'($urandom);
                set_req(prev, OP_ADD, pa[prev], 16'(prev + 1), 16'd0);
            end
        end
    endtask

    task automatic test_fma_block();
        do_reset();
        issue_en = 1'b1;
        set_req(1, OP_FMA, 16'd5, 16'd6, 16'd10);
        set_req(2, OP_ADD, 16'd20, 16'd22, 16'd0);
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL fma_ready_t0: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            #1;
            tests++; if (req_ready !== 4'b0 || alu_valid_in !== 1'b0 || rsp_valid !== 1'b0) begin
                fails++; $display("FAIL fma_blocked_t%0d: got rdy=%b vin=%b rsp=%b want 0000/0/0",
                                  k, req_ready, alu_valid_in, rsp_valid);
            end
            @(negedge clk);
        end
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'd40) begin
            fails++; $display("FAIL fma_rsp: got v=%b id=%0d d=%0d want v=1 id=1 d=40", rsp_valid, rsp_id, rsp_data);
        end
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL fma_next_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'd42) begin
            fails++; $display("FAIL fma_add_rsp: got v=%b id=%0d d=%0d want v=1 id=2 d=42", rsp_valid, rsp_id, rsp_data);
        end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL fma_proto: got %b want 0", proto_err); end
        @(negedge clk);
    endtask

    task automatic test_issue_en_drop();
        do_reset();
        issue_en = 1'b1;
        set_req(0, OP_MUL, 16'hFFFF, 16'd2, 16'd0);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL ien_ready_t0: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        issue_en     = 1'b0;
        set_req(3, OP_ADD, 16'd1, 16'd1, 16'd0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL ien_no_grant_t%0d: got %b want 0000", k, req_ready); end
            if (k == 3) begin
                tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hFFFE) begin
                    fails++; $display("FAIL ien_mul_rsp: got v=%b id=%0d d=%h want v=1 id=0 d=fffe",
                                      rsp_valid, rsp_id, rsp_data);
                end
            end
            @(negedge clk);
        end
        issue_en = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL ien_resume: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'd2) begin
            fails++; $display("FAIL ien_add_rsp: got v=%b id=%0d d=%0d want v=1 id=3 d=2", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mult();
        do_reset();
        issue_en = 1'b1;
        set_req(2, OP_MULI, 16'd9, 16'd9, 16'd0);
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rmid_ready: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'd0 || proto_err !== 1'b0) begin
            fails++; $display("FAIL rmid_reset_vals: got v=%b id=%0d d=%h err=%b want 0/0/0/0",
                              rsp_valid, rsp_id, rsp_data, proto_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_rsp[%0d]: got %b want 0", k, rsp_valid); end
            @(negedge clk);
        end
        set_req(0, OP_ADD, 16'd1, 16'd2, 16'd0);
        set_req(3, OP_ADD, 16'd5, 16'd5, 16'd0);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd3 || proto_err !== 1'b0) begin
            fails++; $display("FAIL rmid_rsp: got v=%b id=%0d d=%0d err=%b want 1/0/3/0",
                              rsp_valid, rsp_id, rsp_data, proto_err);
        end
        @(negedge clk);
    endtask

    task automatic test_proto_err();
        do_reset();
        force_vo = 1'b1;
        #1;
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL perr_before: got %b want 0", proto_err); end
        @(negedge clk);
        force_vo = 1'b0;
        issue_en = 1'b1;
        set_req(1, OP_ADD, 16'd2, 16'd2, 16'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr_sticky[%0d]: got %b want 1", k, proto_err); end
            @(negedge clk);
        end
        do_reset();
        #1;
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL perr_cleared: got %b want 0", proto_err); end
    endtask

    task automatic test_random();
        logic        pv [4];
        logic [4:0]  pop [4];
        logic [15:0] pa [4], pb [4], pc [4];
        bit          ev [0:409];
        int          eid [0:409];
        logic [15:0] ed [0:409];
        int          last, next_ok, grant, j, d;
        do_reset();
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        for (int i = 0; i < 410; i++) begin ev[i] = 1'b0; eid[i] = 0; ed[i] = '0; end
        last    = 3;
        next_ok = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i]  = 1'b1;
                    pop[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
                    pa[i]  = 16'($urandom);
                    pb[i]  = 16'($urandom);
                    pc[i]  = 16'($urandom);
                end
                if (pv[i]) set_req(i, pop[i], pa[i], pb[i], pc[i]);
                else req_valid[i] = 1'b0;
            end
            issue_en = ($urandom_range(0, 3) != 0);
            grant = -1;
            if (c >= next_ok && issue_en) begin
                for (int k = 1; k <= 4; k++) begin
                    j = (last + k) % 4;
                    if (grant < 0 && pv[j]) grant = j;
                end
            end
            #1;
            tests++; if (req_ready !== ((grant >= 0) ? 4'(1 << grant) : 4'b0)) begin
                fails++; $display("FAIL rnd_ready[c%0d]: got %b want grant %0d", c, req_ready, grant);
            end
            tests++; if (rsp_valid !== ev[c] || (ev[c] && (rsp_id !== 2'(eid[c]) || rsp_data !== ed[c]))) begin
                fails++; $display("FAIL rnd_rsp[c%0d]: got v=%b id=%0d d=%h want v=%b id=%0d d=%h",
                                  c, rsp_valid, rsp_id, rsp_data, ev[c], eid[c], ed[c]);
            end
            if (grant >= 0) begin
                tests++; if (alu_cmp_mode !== 2'(grant) || alu_pred_val !== 1'(grant % 2) || alu_op !== pop[grant]) begin
                    fails++; $display("FAIL rnd_pass[c%0d]: got cm=%0d p=%b op=%0d want cm=%0d p=%0d op=%0d",
                                      c, alu_cmp_mode, alu_pred_val, alu_op, grant, grant % 2, pop[grant]);
                end
                d       = c + (is_mult(pop[grant]) ? 3 : 1);
                ev[d]   = 1'b1;
                eid[d]  = grant;
                ed[d]   = alu_fn(pop[grant], pa[grant], pb[grant], pc[grant]);
                next_ok = d;
                last    = grant;
                pv[grant] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rnd_proto: got %b want 0", proto_err); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_fma_block();
        test_issue_en_drop();
        test_reset_mid_mult();
        test_proto_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
